// File: rtl/ipf_lcu_feeder.sv
// Walks a 128x128 frame LCU by LCU, fetching per-LCU parameters and streaming pixels to the filter.
// Define IPF_FEED_PIXCNT_EN to add the saturating pix_cnt beat counter output.
module ipf_lcu_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_lcu_size,
  output logic        done,
  output logic        img_rd,
  output logic [13:0] img_addr,
  input  logic [7:0]  img_data,
  output logic        par_rd,
  output logic [5:0]  par_addr,
  input  logic [23:0] par_data,
  input  logic        busy,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  ipf_type,
  output logic [4:0]  ipf_band_pos,
  output logic        ipf_wo_class,
  output logic [15:0] ipf_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size
`ifdef IPF_FEED_PIXCNT_EN
  ,
  output logic [14:0] pix_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, PARAM, PLOAD, STREAM, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t     state;
  logic [5:0] row_cnt;
  logic [5:0] col_cnt;
  logic       rd_d1;
  logic [5:0] n_last;
  logic [2:0] m_last;
  logic       last_lcu;
  logic [2:0] nx_x;
  logic [2:0] nx_y;
  logic [1:0] size_norm;

  function automatic logic [13:0] pix_addr(input logic [2:0] ly, input logic [2:0] lx,
                                           input logic [5:0] r, input logic [5:0] c,
                                           input logic [1:0] sz);
    logic [6:0] row_v;
    logic [6:0] col_v;
    row_v = (7'(ly) << (3'd4 + 3'(sz))) + 7'(r);
    col_v = (7'(lx) << (3'd4 + 3'(sz))) + 7'(c);
    return {row_v, col_v};
  endfunction

  function automatic logic [5:0] par_index(input logic [2:0] ly, input logic [2:0] lx,
                                           input logic [1:0] sz);
    return (6'(ly) << (2'd3 - sz)) + 6'(lx);
  endfunction

  // lcu_size only ever holds 0..2, so these stay within range
  assign n_last    = 6'((7'd16 << lcu_size) - 7'd1);
  assign m_last    = 3'd7 >> lcu_size;
  assign last_lcu  = (lcu_x == m_last) && (lcu_y == m_last);
  assign nx_x      = (lcu_x == m_last) ? 3'd0 : lcu_x + 3'd1;
  assign nx_y      = (lcu_x == m_last) ? lcu_y + 3'd1 : lcu_y;
  assign size_norm = (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      row_cnt      <= '0;
      col_cnt      <= '0;
      done         <= 1'b0;
      img_rd       <= 1'b0;
      img_addr     <= '0;
      par_rd       <= 1'b0;
      par_addr     <= '0;
      ipf_type     <= '0;
      ipf_band_pos <= '0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= '0;
      lcu_x        <= '0;
      lcu_y        <= '0;
      lcu_size     <= '0;
    end else begin
      par_rd <= 1'b0;
      img_rd <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lcu_size <= size_norm;
            lcu_x    <= '0;
            lcu_y    <= '0;
            done     <= 1'b0;
            par_rd   <= 1'b1;
            par_addr <= '0;
            state    <= PARAM;
          end
        end
        PARAM: state <= PLOAD;
        PLOAD: begin
          ipf_type     <= par_data[23:22];
          ipf_band_pos <= par_data[21:17];
          ipf_wo_class <= par_data[16];
          ipf_offset   <= par_data[15:0];
          row_cnt      <= '0;
          col_cnt      <= '0;
          img_rd       <= 1'b1;
          img_addr     <= pix_addr(lcu_y, lcu_x, 6'd0, 6'd0, lcu_size);
          state        <= STREAM;
        end
        STREAM: begin
          // row_cnt/col_cnt name the read being issued this cycle
          if (col_cnt == n_last) begin
            if (row_cnt >= 6'd2) begin
              state <= WAIT_HI;
            end else begin
              row_cnt  <= row_cnt + 6'd1;
              col_cnt  <= '0;
              img_rd   <= 1'b1;
              img_addr <= pix_addr(lcu_y, lcu_x, row_cnt + 6'd1, 6'd0, lcu_size);
            end
          end else begin
            col_cnt  <= col_cnt + 6'd1;
            img_rd   <= 1'b1;
            img_addr <= pix_addr(lcu_y, lcu_x, row_cnt, col_cnt + 6'd1, lcu_size);
          end
        end
        WAIT_HI: begin
          if (busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!busy) begin
            if (row_cnt != n_last) begin
              row_cnt  <= row_cnt + 6'd1;
              col_cnt  <= '0;
              img_rd   <= 1'b1;
              img_addr <= pix_addr(lcu_y, lcu_x, row_cnt + 6'd1, 6'd0, lcu_size);
              state    <= STREAM;
            end else if (last_lcu) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              lcu_x    <= nx_x;
              lcu_y    <= nx_y;
              par_rd   <= 1'b1;
              par_addr <= par_index(nx_y, nx_x, lcu_size);
              state    <= PARAM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM data lands one cycle after img_rd; one more register puts it on din
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_d1 <= 1'b0;
      in_en <= 1'b0;
      din   <= '0;
    end else begin
      rd_d1 <= img_rd;
      in_en <= rd_d1;
      if (rd_d1) din <= img_data;
    end
  end

`ifdef IPF_FEED_PIXCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
    end else if (start && (state == IDLE || state == DONE)) begin
      pix_cnt <= '0;
    end else if (in_en && pix_cnt != 15'h7FFF) begin
      pix_cnt <= pix_cnt + 15'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Directed bench for ipf_lcu_feeder: a frame-level model predicts every read address, pixel beat and parameter fetch.
module tb_ipf_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_lcu_size = 2'd0;
  logic        done;
  logic        img_rd;
  logic [13:0] img_addr;
  logic [7:0]  img_data = 8'd0;
  logic        par_rd;
  logic [5:0]  par_addr;
  logic [23:0] par_data = 24'd0;
  logic        busy = 1'b0;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
`ifdef IPF_FEED_PIXCNT_EN
  logic [14:0] pix_cnt;
`endif

  ipf_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size), .done(done),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
    .busy(busy), .in_en(in_en), .din(din),
    .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
    .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size)
`ifdef IPF_FEED_PIXCNT_EN
    , .pix_cnt(pix_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] img_fn(input int a);
    return 8'((a & 255) ^ ((a >> 7) * 29) ^ 8'h3C);
  endfunction

  function automatic logic [23:0] par_fn(input int i);
    return 24'(i * 32'h0000B5D3 + 32'h0003C1A7);
  endfunction

  always_ff @(posedge clk) if (img_rd) img_data <= img_fn(int'(img_addr));
  always_ff @(posedge clk) if (par_rd) par_data <= par_fn(int'(par_addr));

  typedef struct packed {
    logic [7:0]  d;
    logic [23:0] p;
    logic [7:0]  l;
  } beat_t;

  beat_t exp_q[$];
  int    addr_q[$];
  bit    gate_q[$];
  int    par_q[$];
  int    rdcyc_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats = 0;
  int last_addr = -1;
  bit gated = 1'b0;
  bit hold_busy = 1'b0;
  int wait_cnt = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, req);
    end
  endtask

  // Frame model: raster of LCUs, raster of pixels inside each, gate after every row >= 2
  task automatic build(input int code);
    int sz, n, m, idx, a;
    beat_t b;
    exp_q.delete(); addr_q.delete(); gate_q.delete(); par_q.delete(); rdcyc_q.delete();
    sz = (code == 3) ? 2 : code;
    n  = 16 << sz;
    m  = 8 >> sz;
    for (int ly = 0; ly < m; ly++) begin
      for (int lx = 0; lx < m; lx++) begin
        idx = ly * m + lx;
        par_q.push_back(idx);
        for (int r = 0; r < n; r++) begin
          for (int c = 0; c < n; c++) begin
            a = (ly * n + r) * 128 + lx * n + c;
            addr_q.push_back(a);
            gate_q.push_back(r >= 2 && c == n - 1);
            b.d = img_fn(a);
            b.p = par_fn(idx);
            b.l = {3'(lx), 3'(ly), 2'(sz)};
            exp_q.push_back(b);
          end
        end
      end
    end
    beats = 0; last_addr = -1; gated = 1'b0; wait_cnt = 0; busy = 1'b0;
  endtask

  task automatic tick();
    beat_t e;
    int rc, a;
    bit g;
    @(negedge clk);
    cyc++;
    if (in_en) begin
      if (exp_q.size() == 0) chk(1'b0, "extra_beat", din, 0);
      else begin
        e  = exp_q.pop_front();
        rc = (rdcyc_q.size() != 0) ? rdcyc_q.pop_front() : -100;
        chk(din == e.d, "din", din, e.d);
        chk({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} == e.p, "params",
            {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, e.p);
        chk({lcu_x, lcu_y, lcu_size} == e.l, "lcu_pos", {lcu_x, lcu_y, lcu_size}, e.l);
        chk(cyc - rc == 2, "latency", cyc - rc, 2);
        beats++;
      end
    end
    if (img_rd) begin
      if (gated) chk(1'b0, "rd_in_stall", img_addr, 0);
      else if (addr_q.size() == 0) chk(1'b0, "extra_rd", img_addr, 0);
      else begin
        a = addr_q.pop_front();
        g = gate_q.pop_front();
        chk(int'(img_addr) == a, "img_addr", img_addr, a);
        rdcyc_q.push_back(cyc);
        last_addr = int'(img_addr);
        if (g) begin gated = 1'b1; wait_cnt = 0; end
      end
    end
    if (par_rd) begin
      if (par_q.size() == 0) chk(1'b0, "extra_par_rd", par_addr, 0);
      else begin
        a = par_q.pop_front();
        chk(int'(par_addr) == a, "par_addr", par_addr, a);
      end
    end
    if (done && exp_q.size() != 0) chk(1'b0, "early_done", exp_q.size(), 0);
    // Filter model: busy pulses 3 cycles high once the feeder has stalled
    if (gated && !hold_busy) begin
      wait_cnt++;
      if (wait_cnt == 3) busy = 1'b1;
      if (wait_cnt == 6) begin busy = 1'b0; gated = 1'b0; end
    end
  endtask

  task automatic pulse_start(input int code);
    cfg_lcu_size = 2'(code);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int code, input bit inject);
    int n;
    bit injected;
    n = 0;
    injected = 1'b0;
    build(code);
    pulse_start(code);
    while (!done && n < 40000) begin
      tick();
      n++;
      if (inject && !injected && beats >= 1000 && img_rd) begin
        pulse_start(0);
        injected = 1'b1;
      end
    end
    chk(done == 1'b1, "done", done, 1);
    chk(beats == 16384, "frame_beats", beats, 16384);
    chk(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
`ifdef IPF_FEED_PIXCNT_EN
    chk(pix_cnt == 15'd16384, "pix_cnt_done", pix_cnt, 16384);
`endif
    $display("frame cfg=%0d beats=%0d cycles=%0d", code, beats, n);
  endtask

  task automatic abort_reset();
    logic [63:0] ob;
    reset = 1'b1;
    #1;
    ob = {done, img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
          ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size};
    chk(ob == 64'd0, "reset_outputs", ob, 0);
`ifdef IPF_FEED_PIXCNT_EN
    chk(pix_cnt == 15'd0, "reset_pix_cnt", pix_cnt, 0);
`endif
    exp_q.delete(); addr_q.delete(); gate_q.delete(); par_q.delete(); rdcyc_q.delete();
    gated = 1'b0; busy = 1'b0; wait_cnt = 0; beats = 0;
    tick();
    reset = 1'b0;
    tick();
    chk(in_en == 1'b0, "in_en_after_reset", in_en, 0);
    repeat (5) tick();
    $display("reset applied, outputs cleared");
  endtask

  initial begin
    int n;
    logic [63:0] ob;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    ob = {done, img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
          ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size};
    chk(ob == 64'd0, "reset_state", ob, 0);
    reset = 1'b0;
    tick();

    // Pin the model against hand-derived addresses
    build(2);
    chk(addr_q[0] == 0, "model_a0", addr_q[0], 0);
    chk(addr_q[63] == 63, "model_a63", addr_q[63], 63);
    chk(addr_q[64] == 128, "model_a64", addr_q[64], 128);
    chk(exp_q.size() == 16384, "model_total", exp_q.size(), 16384);
    build(0);
    chk(par_q[1] == 1, "model_par1", par_q[1], 1);
    chk(addr_q[256] == 16, "model_lcu10_first", addr_q[256], 16);
    chk(addr_q[303] == 287, "model_lcu10_row2_last", addr_q[303], 287);
    chk(gate_q[303] == 1'b1, "model_lcu10_gate", gate_q[303], 1);

    // Full 64x64 frame with a stray start during streaming
    run_frame(2, 1'b1);

    // Filter never raises busy: stuck after row 2 of the first LCU
    build(0);
    hold_busy = 1'b1;
    pulse_start(0);
    repeat (400) tick();
    chk(beats == 48, "hold_beats", beats, 48);
    chk(gated == 1'b1, "hold_stalled", gated, 1);
    $display("busy hold: beats=%0d", beats);
    hold_busy = 1'b0;
    abort_reset();

    // Size code 3 behaves as 64x64 (lcu_size checked on each beat)
    build(3);
    pulse_start(3);
    repeat (300) tick();
    chk(beats > 192, "code3_beats", beats, 193);
    $display("code3 partial: beats=%0d", beats);
    abort_reset();

    // Abort in row 5 of LCU (2,1) at 16x16, then restart from scratch
    build(0);
    pulse_start(0);
    n = 0;
    while (last_addr != 2723 && n < 8000) begin tick(); n++; end
    chk(last_addr == 2723, "reach_abort_point", last_addr, 2723);
    $display("abort point reached after %0d cycles", n);
    abort_reset();
    run_frame(0, 1'b0);

    // 32x32 frame started from the done state
    run_frame(1, 1'b0);
`ifdef IPF_FEED_PIXCNT_EN
    build(1);
    pulse_start(1);
    chk(pix_cnt == 15'd0, "pix_cnt_cleared", pix_cnt, 0);
    abort_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
